// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - byte stream in, instruction memory write port out
interface inst_loader_if #(
  parameter int ADDR_W = 16
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - length-prefixed byte stream to instruction memory loader
module inst_loader #(
  parameter int ADDR_W    = 16,
  parameter int BASE_WORD = 0
) (
  input  logic        clk,
  input  logic        rst,
  inst_loader_if.slave bus,
  input  logic        start,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Words available from BASE_WORD up to the top of memory; 33 bits so that
  // ADDR_W up to 32 and the full 32-bit header compare never overflow.
  localparam logic [32:0]       CAPACITY  = (33'd1 << ADDR_W) - 33'(BASE_WORD);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);

  state_t            state;
  state_t            next_state;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   index;
  logic              accept;
  logic              last_byte;
  logic [31:0]       word_next;

  assign bus.byte_ready = (state == S_HDR) || (state == S_DATA);
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign last_byte      = accept && (byte_cnt == 2'd3);
  // New byte enters at the top; after four shifts the first byte sits in [7:0].
  assign word_next      = {bus.byte_data, shreg};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HDR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_HDR: begin
        if (last_byte) begin
          if (word_next == 32'd0) begin
            next_state = S_DONE;
          end else if ({1'b0, word_next} > CAPACITY) begin
            next_state = S_ERR;
          end else begin
            next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if ((index + 1'b1) == n_words) begin
          next_state = S_DONE;
        end else begin
          next_state = S_DATA;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          next_state = S_HDR;
        end
      end
      default: next_state = S_HDR;
    endcase
  end

  // Byte assembly, memory write port, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt      <= 2'd0;
      shreg         <= 24'd0;
      n_words       <= '0;
      index         <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= 32'd0;
      checksum      <= 32'd0;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_hold      <= 1'b1;
    end else begin
      bus.mem_we <= 1'b0;
      done       <= (next_state == S_DONE);
      error      <= (next_state == S_ERR);
      cpu_hold   <= (next_state != S_DONE);

      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shreg    <= word_next[31:8];
      end

      // Only the low ADDR_W+1 bits matter once the capacity check has passed.
      if (state == S_HDR && last_byte) begin
        n_words <= word_next[ADDR_W:0];
      end

      if (state == S_DATA && last_byte) begin
        bus.mem_we    <= 1'b1;
        bus.mem_waddr <= BASE_ADDR + index[ADDR_W-1:0];
        bus.mem_wdata <= word_next;
      end

      if (state == S_WRITE) begin
        checksum <= checksum + bus.mem_wdata;
        index    <= index + 1'b1;
      end

      if ((state == S_DONE || state == S_ERR) && start) begin
        index    <= '0;
        byte_cnt <= 2'd0;
        checksum <= 32'd0;
      end
    end
  end

endmodule
